// File: rtl/rating_viewer.sv
// Read-side viewer for the four-user rating store: manual/auto browsing of the
// selected user's ratings plus a sequential scan for the top-scoring user.
module rating_viewer #(
  parameter logic [1:0] VIEW_STATE = 2'b11,
  parameter int         AUTO_TICKS = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] state,
  input  logic       nextbtn,
  input  logic       autobtn,
  input  logic       rankbtn,
  input  logic [3:0] u0_r1,
  input  logic [3:0] u0_r2,
  input  logic [3:0] u1_r1,
  input  logic [3:0] u1_r2,
  input  logic [3:0] u2_r1,
  input  logic [3:0] u2_r2,
  input  logic [3:0] u3_r1,
  input  logic [3:0] u3_r2,
  output logic [1:0] sel_user,
  output logic [3:0] shown_r1,
  output logic [3:0] shown_r2,
  output logic [4:0] shown_total,
  output logic       auto_en,
  output logic [1:0] best_user,
  output logic [4:0] best_total,
  output logic       rank_valid,
  output logic       rank_busy
);

  localparam int            TW = $clog2(AUTO_TICKS);
  localparam logic [TW-1:0] TC = TW'(AUTO_TICKS - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} rank_state_t;

  rank_state_t rank_state, rank_next;
  logic        scan_start;

  logic          next_q, auto_q, rank_q;
  logic [1:0]    state_q;
  logic [TW-1:0] timer;
  logic [1:0]    idx;
  logic [1:0]    acc_user;
  logic [4:0]    acc_total;

  logic [3:0] r1 [4];
  logic [3:0] r2 [4];
  logic [4:0] tot [4];

  assign r1[0] = u0_r1;
  assign r2[0] = u0_r2;
  assign r1[1] = u1_r1;
  assign r2[1] = u1_r2;
  assign r1[2] = u2_r1;
  assign r2[2] = u2_r2;
  assign r1[3] = u3_r1;
  assign r2[3] = u3_r2;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_total
      assign tot[gi] = {1'b0, r1[gi]} + {1'b0, r2[gi]};
    end
  endgenerate

  logic in_view, entry, next_pulse, auto_pulse, rank_pulse, tc;

  assign in_view    = (state == VIEW_STATE);
  assign entry      = in_view && (state_q != VIEW_STATE);
  assign next_pulse = nextbtn & ~next_q;
  assign auto_pulse = autobtn & ~auto_q;
  assign rank_pulse = rankbtn & ~rank_q;
  assign tc         = auto_en && (timer == TC);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      next_q  <= 1'b0;
      auto_q  <= 1'b0;
      rank_q  <= 1'b0;
      state_q <= 2'b00;
    end else begin
      next_q  <= nextbtn;
      auto_q  <= autobtn;
      rank_q  <= rankbtn;
      state_q <= state;
    end
  end

  // Selection, auto-scroll timer and display registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_user    <= 2'd0;
      shown_r1    <= 4'd0;
      shown_r2    <= 4'd0;
      shown_total <= 5'd0;
      auto_en     <= 1'b0;
      timer       <= '0;
    end else if (in_view) begin
      shown_r1    <= r1[sel_user];
      shown_r2    <= r2[sel_user];
      shown_total <= tot[sel_user];
      if (auto_pulse) begin
        // A toggle swallows a coinciding terminal count.
        auto_en <= ~auto_en;
        timer   <= '0;
        if (next_pulse) sel_user <= sel_user + 2'd1;
      end else begin
        if (next_pulse || tc) sel_user <= sel_user + 2'd1;
        if (auto_en) timer <= (next_pulse || tc) ? '0 : timer + TW'(1);
      end
    end else begin
      auto_en <= 1'b0;
      timer   <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rank_state <= IDLE;
    else        rank_state <= rank_next;
  end

  always_comb begin
    rank_next  = rank_state;
    scan_start = 1'b0;
    case (rank_state)
      IDLE: begin
        if (in_view && (entry || rank_pulse)) begin
          rank_next  = SCAN;
          scan_start = 1'b1;
        end
      end
      SCAN: begin
        if (!in_view)         rank_next = IDLE;
        else if (idx == 2'd3) rank_next = DONE;
      end
      DONE:    rank_next = IDLE;
      default: rank_next = IDLE;
    endcase
  end

  assign rank_busy = (rank_state == SCAN);

  // Scan datapath; strict compare keeps the lowest index on ties.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx        <= 2'd0;
      acc_user   <= 2'd0;
      acc_total  <= 5'd0;
      best_user  <= 2'd0;
      best_total <= 5'd0;
      rank_valid <= 1'b0;
    end else if (scan_start) begin
      idx        <= 2'd0;
      acc_user   <= 2'd0;
      acc_total  <= 5'd0;
      rank_valid <= 1'b0;
    end else if (in_view && rank_state == SCAN) begin
      if (tot[idx] > acc_total) begin
        acc_user  <= idx;
        acc_total <= tot[idx];
      end
      idx <= idx + 2'd1;
    end else if (in_view && rank_state == DONE) begin
      best_user  <= acc_user;
      best_total <= acc_total;
      rank_valid <= 1'b1;
    end
  end

endmodule
